lab1_imul_mul_requester: RTL and testbench
==========================================

# lab1_imul_mul_requester

Requester-side front end for the lab1 integer multiplier: it drives the multiplier's `req` port and consumes its `resp` port. Upstream logic streams operand pairs, each pair marked last or not. The block forwards each pair as a 64-bit multiply request and accumulates the returned 32-bit products. After the final product of a job arrives, it presents the sum on a result val/rdy port. It sits between a job source (test harness or processor accelerator port) and any `lab1_imul_IntMul*` implementation, and works with any multiplier latency.

## Interface
- `MAX_OUTSTANDING`, default 1 — maximum requests in flight to the multiplier; legal range 1..15.
- `clk`  in  1  — clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low; 0 forces the reset state immediately.
- `opnd_val`  in  1  — upstream operand pair valid.
- `opnd_rdy`  out  1  — block can accept the operand pair.
- `opnd_msg`  in  64  — {a[63:32], b[31:0]}.
- `opnd_last`  in  1  — this pair is the final one of the job; qualified by `opnd_val`.
- `mreq_val`  out  1  — multiply request valid; connects to multiplier `req_val`.
- `mreq_rdy`  in  1  — multiplier `req_rdy`.
- `mreq_msg`  out  64  — multiplier `req_msg`.
- `mresp_val`  in  1  — multiplier `resp_val`.
- `mresp_rdy`  out  1  — multiplier `resp_rdy`.
- `mresp_msg`  in  32  — product, low 32 bits.
- `result_val`  out  1  — job sum valid.
- `result_rdy`  in  1  — downstream accepts the sum.
- `result_msg`  out  32  — accumulated sum of products.

## Operation
- Fire conventions: `opnd_go = opnd_val & opnd_rdy`, `mreq_go = mreq_val & mreq_rdy`, `mresp_go = mresp_val & mresp_rdy`, `result_go = result_val & result_rdy`.
- State registers:
  - FSM state: ISSUE, DRAIN, DONE.
  - `outstanding`: $clog2(MAX_OUTSTANDING+1) bits.
  - `acc`: 32 bits.
- ISSUE:
  - `credit = (outstanding != MAX_OUTSTANDING)`.
  - `mreq_val = opnd_val & credit`; `opnd_rdy = mreq_rdy & credit`; `mreq_msg = opnd_msg`. This is a combinational pass-through, so `opnd_go == mreq_go`.
  - `opnd_go & opnd_last` → DRAIN.
- DRAIN:
  - `opnd_rdy = mreq_val = 0`.
  - Next `outstanding == 0` → DONE. This includes the cycle in which the final response is accepted.
- DONE:
  - `result_val = 1`, `result_msg = acc`.
  - `opnd_rdy = 0`, `mresp_rdy = 0`.
  - `result_go` → ISSUE, with `acc <= 0` in the same edge.
- In all states, `mresp_rdy = (outstanding != 0) & (state != DONE)`. Responses arriving with nothing outstanding are never accepted.
- Counter update per edge: `outstanding <= outstanding + mreq_go - mresp_go`. Simultaneous issue and response leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- Accumulate: on `mresp_go`, `acc <= acc + mresp_msg`, modulo 2^32 (see Configuration).
- Products are summed in arrival order. Addition is commutative, so out-of-order multipliers are tolerated.
- `mreq_msg` is driven from `opnd_msg` in every state. Its value is don't-care when `mreq_val = 0`.

## Timing
- Reset values:
  - state = ISSUE, `outstanding = 0`, `acc = 0`.
  - Hence `result_val = 0`, `mresp_rdy = 0`, `result_msg = 0`, `opnd_rdy = mreq_rdy`, `mreq_val = opnd_val`.
- Request path has zero latency: an operand accepted in cycle t is a multiplier request in cycle t.
- `result_val` rises the cycle after the edge that accepts the final response. It stays high, with `result_msg` stable, until `result_go`.
- With MAX_OUTSTANDING = 1 and a multiplier of latency L, each pair occupies L+1 or more cycles. No back-to-back issue happens until a credit returns.
- Reset mid-job (ISSUE/DRAIN/DONE): the partial sum and credits are discarded asynchronously. The attached multiplier must share this reset so that no stale response returns.
- The first ISSUE cycle after reset deassertion may accept an operand.

## Configuration
- `LAB1_IMUL_REQ_SAT_EN` defined: accumulation is unsigned-saturating. If `acc + mresp_msg` carries out of bit 31, `acc <= 32'hFFFF_FFFF`, and it stays saturated until cleared.
- Undefined (default): accumulation wraps modulo 2^32 and the carry is discarded.

## Test plan
- Single pair, last=1: a=3, b=4, multiplier latency 34, MAX_OUTSTANDING=1 → one request `mreq_msg=64'h00000003_00000004`, then `result_msg=32'd12`, `result_val` held until `result_rdy`.
- Three-pair job {(2,5),(7,3),(0xFFFF,0x10001)} → sum 10+21+0xFFFFFFFF wraps to 32'd30 without SAT_EN, and 32'hFFFF_FFFF with SAT_EN.
- MAX_OUTSTANDING=4 with a 1-cycle-latency responder model, 8 pairs of (i,i) for i=1..8:
  - `outstanding` never exceeds 4.
  - Simultaneous issue/response cycles keep the count.
  - `result_msg=32'd204`.
- Back-pressure: `mreq_rdy` low for 5 cycles → `opnd_rdy` low throughout, with no operand lost or duplicated. `result_rdy` low for 10 cycles in DONE → `result_msg` stable and `mresp_rdy=0`.
- Back-to-back jobs (1,1,last) then (2,2,last) → results 1 then 4; the second job starts the cycle after `result_go` with `acc=0`.
- Assert reset (low) during DRAIN with 1 outstanding → `result_val=0` and `mresp_rdy=0` immediately. After release, job (6,7,last) → 42.

Source files
------------

// File: rtl/lab1_imul_mul_requester.sv
// Requester front end for the lab1 integer multiplier: streams operand pairs out as multiply requests and sums the returned products per job.
// Latency: operand-to-request is zero cycles (combinational); the result is valid the cycle after the last product is accepted.
// Backpressure: operands stall on mreq_rdy or exhausted credits; while the sum waits on result_rdy, new operands and responses are refused.
// Optional build macro LAB1_IMUL_REQ_SAT_EN: accumulate with unsigned saturation instead of wrapping modulo 2^32.
module lab1_imul_mul_requester #(
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opnd_val,
    output logic        opnd_rdy,
    input  logic [63:0] opnd_msg,
    input  logic        opnd_last,
    output logic        mreq_val,
    input  logic        mreq_rdy,
    output logic [63:0] mreq_msg,
    input  logic        mresp_val,
    output logic        mresp_rdy,
    input  logic [31:0] mresp_msg,
    output logic        result_val,
    input  logic        result_rdy,
    output logic [31:0] result_msg
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [31:0]     acc;
    logic [31:0]     acc_sum;
    logic            credit;
    logic            in_issue;
    logic            opnd_go;
    logic            mreq_go;
    logic            mresp_go;
    logic            result_go;

    // A credit is available while fewer than MAX_OUTSTANDING requests are in flight.
    assign credit   = (outstanding != MAX_CNT);
    assign in_issue = (state == ISSUE);

    // Operands pass straight through to the multiplier, so accepting one is issuing it.
    assign mreq_val = in_issue & opnd_val & credit;
    assign opnd_rdy = in_issue & mreq_rdy & credit;
    assign mreq_msg = opnd_msg;

    // Only take responses we are owed, and freeze the sum while it is being presented.
    assign mresp_rdy = (outstanding != '0) & (state != DONE);

    assign result_val = (state == DONE);
    assign result_msg = acc;

    assign opnd_go   = opnd_val & opnd_rdy;
    assign mreq_go   = mreq_val & mreq_rdy;
    assign mresp_go  = mresp_val & mresp_rdy;
    assign result_go = result_val & result_rdy;

    // In-flight count after this edge; a simultaneous issue and response cancel out.
    always_comb begin
        outstanding_next = outstanding;
        if (mreq_go && !mresp_go) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!mreq_go && mresp_go) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

`ifdef LAB1_IMUL_REQ_SAT_EN
    logic [32:0] acc_wide;

    // Saturating add: any carry out of bit 31 pins the sum at all-ones.
    always_comb begin
        acc_wide = {1'b0, acc} + {1'b0, mresp_msg};
        acc_sum  = acc_wide[32] ? 32'hFFFF_FFFF : acc_wide[31:0];
    end
`else
    // Wrapping add: the carry out of bit 31 is dropped.
    always_comb begin
        acc_sum = acc + mresp_msg;
    end
`endif

    // Job sequencing, credit counter and accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ISSUE;
            outstanding <= '0;
            acc         <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (mresp_go) begin
                acc <= acc_sum;
            end
            case (state)
                ISSUE: begin
                    if (opnd_go && opnd_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Includes the edge that accepts the final response.
                    if (outstanding_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_go) begin
                        state <= ISSUE;
                        acc   <= '0;
                    end
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab1_imul_mul_requester.sv
// Self-checking bench for lab1_imul_mul_requester with a behavioural multiplier responder of configurable latency.
// Every cycle the DUT handshake outputs are compared against a job-level model; literal job sums pin the model.
// Stimulus is a set of directed jobs covering latency, credits, back-pressure, back-to-back jobs and mid-job reset.
module tb_lab1_imul_mul_requester;

    localparam int MAXO = 4;

    logic        clk;
    logic        reset;
    logic        opnd_val;
    logic        opnd_rdy;
    logic [63:0] opnd_msg;
    logic        opnd_last;
    logic        mreq_val;
    logic        mreq_rdy;
    logic [63:0] mreq_msg;
    logic        mresp_val;
    logic        mresp_rdy;
    logic [31:0] mresp_msg;
    logic        result_val;
    logic        result_rdy;
    logic [31:0] result_msg;

    lab1_imul_mul_requester #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk        (clk),
        .reset      (reset),
        .opnd_val   (opnd_val),
        .opnd_rdy   (opnd_rdy),
        .opnd_msg   (opnd_msg),
        .opnd_last  (opnd_last),
        .mreq_val   (mreq_val),
        .mreq_rdy   (mreq_rdy),
        .mreq_msg   (mreq_msg),
        .mresp_val  (mresp_val),
        .mresp_rdy  (mresp_rdy),
        .mresp_msg  (mresp_msg),
        .result_val (result_val),
        .result_rdy (result_rdy),
        .result_msg (result_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    // Job-level model state
    int          m_inflight;
    logic [31:0] m_sum;
    bit          m_last_sent;
    bit          m_present;

    // Responder (multiplier) model
    int          lat;
    int          cyc;
    int          due_q[$];
    logic [31:0] prod_q[$];

    // Observations
    bit          last_og;
    logic [63:0] last_req_msg;
    logic [31:0] last_result;
    int          dut_inflight;
    int          max_inflight;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_inflight   = 0;
        m_sum        = '0;
        m_last_sent  = 0;
        m_present    = 0;
        due_q.delete();
        prod_q.delete();
        mresp_val    = 1'b0;
        mresp_msg    = '0;
        dut_inflight = 0;
    endtask

    // One clock cycle: check at negedge, then advance model/responder just after posedge.
    task automatic cycle();
        bit issue_ok, e_opnd_rdy, e_mreq_val, e_mresp_rdy;
        bit og, rg, sg;
        logic [63:0] prod64;
        logic [32:0] t;
        @(negedge clk);
        issue_ok    = !m_last_sent && !m_present && (m_inflight < MAXO);
        e_opnd_rdy  = issue_ok && mreq_rdy;
        e_mreq_val  = issue_ok && opnd_val;
        e_mresp_rdy = (m_inflight != 0) && !m_present;
        chk("opnd_rdy", opnd_rdy, e_opnd_rdy);
        chk("mreq_val", mreq_val, e_mreq_val);
        chk("mresp_rdy", mresp_rdy, e_mresp_rdy);
        chk("result_val", result_val, m_present);
        if (m_present) chk("result_msg", result_msg, m_sum);
        if (e_mreq_val) chk("mreq_msg", mreq_msg, opnd_msg);
        og = e_opnd_rdy && opnd_val;
        rg = mresp_val && e_mresp_rdy;
        sg = m_present && result_rdy;
        last_og = og;
        if (og) last_req_msg = mreq_msg;
        if (sg) last_result = result_msg;
        dut_inflight += int'(mreq_val && mreq_rdy) - int'(mresp_val && mresp_rdy);
        if (dut_inflight > max_inflight) max_inflight = dut_inflight;
        prod64 = 64'(opnd_msg[63:32]) * 64'(opnd_msg[31:0]);
        @(posedge clk);
        #1;
        cyc++;
        if (rg) begin
            t = {1'b0, m_sum} + {1'b0, prod_q[0]};
`ifdef LAB1_IMUL_REQ_SAT_EN
            m_sum = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
            m_sum = t[31:0];
`endif
            m_inflight--;
            void'(due_q.pop_front());
            void'(prod_q.pop_front());
        end
        if (og) begin
            m_inflight++;
            if (opnd_last) m_last_sent = 1;
            due_q.push_back(cyc + lat - 1);
            prod_q.push_back(prod64[31:0]);
        end
        if (m_last_sent && m_inflight == 0) begin
            m_last_sent = 0;
            m_present   = 1;
        end
        if (sg) begin
            m_present = 0;
            m_sum     = '0;
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mresp_val = 1'b1;
            mresp_msg = prod_q[0];
        end else begin
            mresp_val = 1'b0;
            mresp_msg = 32'hDEAD_BEEF;
        end
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input bit last, output int n);
        bit fired;
        opnd_val  = 1'b1;
        opnd_msg  = {a, b};
        opnd_last = last;
        n = 0;
        fired = 0;
        while (!fired && n < 300) begin
            cycle();
            n++;
            fired = last_og;
        end
        chk("operand_accepted", fired, 1'b1);
        opnd_val  = 1'b0;
        opnd_last = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [31:0] exp, input int hold);
        int n;
        result_rdy = 1'b0;
        n = 0;
        while (!m_present && n < 500) begin
            cycle();
            n++;
        end
        chk("result_arrives", m_present, 1'b1);
        repeat (hold) cycle();
        result_rdy = 1'b1;
        cycle();
        result_rdy = 1'b0;
        chk(nm, last_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall_fires;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] exp3;

        reset      = 1'b0;
        opnd_val   = 1'b1;
        opnd_msg   = 64'h0000_0009_0000_0009;
        opnd_last  = 1'b0;
        mreq_rdy   = 1'b1;
        result_rdy = 1'b0;
        lat        = 1;
        cyc        = 0;
        last_result  = '0;
        last_req_msg = '0;
        max_inflight = 0;
        model_reset();

        // Reset state: pass-through handshakes, nothing to present
        #3;
        chk("rst_result_val", result_val, 1'b0);
        chk("rst_mresp_rdy", mresp_rdy, 1'b0);
        chk("rst_result_msg", result_msg, 32'd0);
        chk("rst_opnd_rdy", opnd_rdy, 1'b1);
        chk("rst_mreq_val", mreq_val, 1'b1);
        opnd_val = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single pair, long multiplier latency
        lat = 34;
        send_pair(32'd3, 32'd4, 1'b1, n);
        chk("single_req_msg", last_req_msg, 64'h0000_0003_0000_0004);
        chk("single_first_cycle", n, 1);
        wait_result("single_sum", 32'd12, 3);

        // Three-pair job with wrap (or saturation)
        lat = 3;
        ta = '{32'd2, 32'd7, 32'h0000_FFFF};
        tb = '{32'd5, 32'd3, 32'h0001_0001};
        for (int i = 0; i < 3; i++) send_pair(ta[i], tb[i], i == 2, n);
`ifdef LAB1_IMUL_REQ_SAT_EN
        exp3 = 32'hFFFF_FFFF;
`else
        exp3 = 32'd30;
`endif
        wait_result("three_pair_sum", exp3, 10);

        // Streaming (i,i) at 1-cycle latency: issue and response overlap
        lat = 1;
        max_inflight = 0;
        for (int i = 1; i <= 8; i++) send_pair(32'(i), 32'(i), i == 8, n);
        wait_result("stream8_sum", 32'd204, 0);
        chk("stream8_max_le", max_inflight <= MAXO, 1'b1);

        // Long latency: credits run out at MAXO
        lat = 8;
        max_inflight = 0;
        for (int i = 1; i <= 6; i++) send_pair(32'(i), 32'(i), i == 6, n);
        wait_result("credit6_sum", 32'd91, 2);
        chk("credit6_max_inflight", max_inflight, MAXO);

        // Multiplier back-pressure for 5 cycles on the first operand
        lat = 2;
        mreq_rdy  = 1'b0;
        opnd_val  = 1'b1;
        opnd_msg  = {32'd10, 32'd10};
        opnd_last = 1'b0;
        stall_fires = 0;
        repeat (5) begin
            cycle();
            stall_fires += int'(last_og);
        end
        chk("stall_no_fire", stall_fires, 0);
        mreq_rdy = 1'b1;
        send_pair(32'd10, 32'd10, 1'b0, n);
        send_pair(32'd3, 32'd3, 1'b1, n);
        wait_result("stall_sum", 32'd109, 10);

        // Back-to-back jobs
        lat = 2;
        send_pair(32'd1, 32'd1, 1'b1, n);
        wait_result("b2b_first", 32'd1, 0);
        send_pair(32'd2, 32'd2, 1'b1, n);
        chk("b2b_start_cycle", n, 1);
        wait_result("b2b_second", 32'd4, 0);

        // Reset asserted during DRAIN with one request outstanding
        lat = 40;
        send_pair(32'd5, 32'd5, 1'b1, n);
        cycle();
        cycle();
        chk("drain_mresp_rdy", mresp_rdy, 1'b1);
        reset = 1'b0;
        #2;
        chk("midrst_result_val", result_val, 1'b0);
        chk("midrst_mresp_rdy", mresp_rdy, 1'b0);
        chk("midrst_opnd_rdy", opnd_rdy, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        lat = 3;
        send_pair(32'd6, 32'd7, 1'b1, n);
        wait_result("post_reset_sum", 32'd42, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
